// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side bus of uart_tx_fifo.
// UART_TX_CTS_EN adds the active-low clear-to-send input i_Cts_n.
interface uart_tx_fifo_if #(parameter int FIFO_DEPTH = 16);
    logic                          i_Tx_DV;
    logic [7:0]                    i_Tx_Byte;
    logic                          o_Tx_Ready;
    logic                          o_Tx_Overflow;
    logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count;
    logic                          o_Tx_Serial;
    logic                          o_Tx_Active;
    logic                          o_Tx_Done;
`ifdef UART_TX_CTS_EN
    logic                          i_Cts_n;
    modport master (output i_Tx_DV, i_Tx_Byte, i_Cts_n,
                    input o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Serial, o_Tx_Active, o_Tx_Done);
    modport slave (input i_Tx_DV, i_Tx_Byte, i_Cts_n,
                   output o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Serial, o_Tx_Active, o_Tx_Done);
`else
    modport master (output i_Tx_DV, i_Tx_Byte,
                    input o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Serial, o_Tx_Active, o_Tx_Done);
    modport slave (input i_Tx_DV, i_Tx_Byte,
                   output o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Serial, o_Tx_Active, o_Tx_Done);
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 5-8 data bits, optional parity, 1-2 stop bits.
// Define UART_TX_CTS_EN to gate frame starts on a synchronised active-low i_Cts_n.
module uart_tx_fifo #(
    parameter int CLK_DIV      = 8,
    parameter int CLKS_PER_BIT = 130,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input logic           osc_clk,
    input logic           i_Rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [7:0] MASK = 8'(255 >> (8 - DATA_BITS));
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t        state, state_n;
    logic [PW-1:0] pcnt;
    logic [BW-1:0] bitcnt;
    logic [2:0]    idx, idx_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_n;
    logic [7:0]    shreg, shreg_n, head;
    logic          par, par_n, line_n, done_n;
    logic          tick, bit_end, go, avail, push, pop;
    logic          serial, active, done, ovf, ready;
`ifdef UART_TX_CTS_EN
    logic [1:0]    cts_sync;
    always_ff @(posedge osc_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) cts_sync <= 2'b11;
        else          cts_sync <= {cts_sync[0], bus.i_Cts_n};
    end
    assign go = !cts_sync[1];
`else
    assign go = 1'b1;
`endif
    assign tick    = pcnt == PW'(CLK_DIV - 1);
    assign bit_end = tick && bitcnt == BW'(CLKS_PER_BIT - 1);
    assign avail   = count != '0 && go;
    assign push    = bus.i_Tx_DV && count != CW'(FIFO_DEPTH);
    assign head    = mem[rptr] & MASK;
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: if (tick && avail) begin
                pop     = 1'b1;
                state_n = START;
            end
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end && idx == 3'(DATA_BITS - 1)) state_n = PARITY != 0 ? PAR : STOP;
            PAR: if (bit_end) state_n = STOP;
            STOP: if (bit_end && idx == 3'(STOP_BITS - 1)) begin
                done_n  = 1'b1;
                pop     = avail;
                state_n = avail ? START : IDLE;
            end
            default: state_n = IDLE;
        endcase
        idx_n   = state_n != state ? 3'd0 : bit_end ? idx + 3'd1 : idx;
        shreg_n = pop ? head : (state == DATA && bit_end) ? shreg >> 1 : shreg;
        par_n   = pop ? (PARITY == 1) ^ (^head) : par;
        // Line is registered from the next state so it changes on the same edge as the FSM.
        line_n  = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PAR ? par_n : 1'b1;
        count_n = count + CW'(push) - CW'(pop);
    end
    always_ff @(posedge osc_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state  <= IDLE;
            pcnt   <= '0;
            bitcnt <= '0;
            idx    <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            serial <= 1'b1;
            active <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            ready  <= 1'b1;
        end else begin
            state  <= state_n;
            pcnt   <= tick ? '0 : pcnt + 1'b1;
            bitcnt <= (state == IDLE || bit_end) ? '0 : tick ? bitcnt + 1'b1 : bitcnt;
            idx    <= idx_n;
            shreg  <= shreg_n;
            par    <= par_n;
            wptr   <= push ? wptr + 1'b1 : wptr;
            rptr   <= pop ? rptr + 1'b1 : rptr;
            count  <= count_n;
            serial <= line_n;
            active <= state_n != IDLE;
            done   <= done_n;
            ovf    <= bus.i_Tx_DV && count == CW'(FIFO_DEPTH);
            ready  <= count_n != CW'(FIFO_DEPTH);
        end
    end
    always_ff @(posedge osc_clk) begin
        if (push) mem[wptr] <= bus.i_Tx_Byte;
    end
    assign bus.o_Tx_Serial   = serial;
    assign bus.o_Tx_Active   = active;
    assign bus.o_Tx_Done     = done;
    assign bus.o_Tx_Overflow = ovf;
    assign bus.o_Tx_Ready    = ready;
    assign bus.o_Fifo_Count  = count;
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the SDR control/telemetry path.
- Frame format is configurable: 5–8 data bits, optional odd/even parity, 1 or 2 stop bits.
- A write FIFO decouples the producer from line timing, so frames go out back-to-back with no idle gap.
- Bit timing comes from a clock-enable prescaler on osc_clk; there is no derived clock.

Parameters:
CLK_DIV, 8, osc_clk cycles per prescaler tick (>=1)
CLKS_PER_BIT, 130, ticks per UART bit (120 MHz / 8 / 115200); bit period = CLK_DIV*CLKS_PER_BIT osc_clk cycles
DATA_BITS, 8, data bits per frame, 5..8
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, entries, power of two >=2

Ports:
osc_clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Tx_DV  in  1  write strobe, one byte per cycle
i_Tx_Byte  in  8  data; bits above DATA_BITS-1 ignored
o_Tx_Ready  out  1  FIFO not full
o_Tx_Overflow  out  1  one-cycle pulse, write attempted while full
o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  entries held
o_Tx_Serial  out  1  serial line, registered
o_Tx_Active  out  1  frame in progress
o_Tx_Done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Single clock domain (osc_clk); all outputs registered.
- Reset (asynchronous assert, synchronous-release use assumed upstream):
  - o_Tx_Serial=1; o_Tx_Active, o_Tx_Done, o_Tx_Overflow = 0.
  - FIFO empty, so o_Fifo_Count=0 and o_Tx_Ready=1.
  - Prescaler and bit counter = 0; FSM in IDLE.
  - Reset mid-frame aborts immediately; the line returns high at once and queued data is discarded.
- Prescaler:
  - Counts 0..CLK_DIV-1 and asserts tick on the cycle it holds CLK_DIV-1, then wraps.
  - Free-running, never stalled.
  - CLK_DIV=1 means a tick every cycle.
- FIFO writes:
  - Write accepted when i_Tx_DV=1 and count<FIFO_DEPTH.
  - Write while full: dropped, FIFO unchanged, o_Tx_Overflow pulses the next cycle.
  - Push and pop in the same cycle: both occur, count unchanged.
  - Push into an empty FIFO is not visible to the FSM until the following cycle.
  - o_Tx_Ready = (count != FIFO_DEPTH); it updates the cycle after a push or pop.
- FSM: every transition occurs only on a tick. bitcnt counts ticks 0..CLKS_PER_BIT-1; a state ends on the tick where bitcnt=CLKS_PER_BIT-1.
  - IDLE: line=1. On tick with FIFO non-empty: pop the head into the shift register, compute parity, go to START, set o_Tx_Active=1.
  - START: line=0 for one bit, then go to DATA.
  - DATA: line = shreg[0], LSB first. Shift after each bit. After DATA_BITS bits go to PAR if PARITY!=0, else to STOP.
  - PAR: line = parity bit for one bit.
    - even: XOR of the DATA_BITS data bits.
    - odd: inverse of that XOR.
  - STOP: line=1 for STOP_BITS bit periods. At the end o_Tx_Done pulses for exactly one osc_clk cycle. Then:
    - FIFO non-empty: pop and go directly to START. o_Tx_Active stays 1, no idle bit.
    - FIFO empty: go to IDLE and clear o_Tx_Active.
- Line timing:
  - Latency from the first write into an idle, empty block to the start-bit falling edge: at most CLK_DIV+2 cycles.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV * CLKS_PER_BIT cycles, exact.
- Counter widths: prescaler and bitcnt sized by $clog2, minimum 1 bit; no overflow at the parameter maxima.

Optional Feature:
UART_TX_CTS_EN — adds input i_Cts_n (1 bit, active-low clear-to-send).
- Defined:
  - i_Cts_n passes through a 2-flop synchroniser inside the block.
  - A new frame is popped (from IDLE, or chained from STOP) only if the synchronised CTS is low.
  - CTS deasserting mid-frame does not interrupt that frame.
  - With CTS high, the FSM waits in IDLE, line=1, o_Tx_Active=0.
- Undefined: no port; transmission is never gated.

Test Plan:
1. CLK_DIV=2, CLKS_PER_BIT=4, 8N1; write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 at 8 cycles per bit; 80-cycle frame; one o_Tx_Done pulse; o_Tx_Active low afterwards.
2. Same parameters, DATA_BITS=7, PARITY=2, STOP_BITS=2; write 0xD3 -> data bits 1,1,0,0,1,0,1, parity bit 0, two stop bits; bit 7 ignored; frame 88 cycles.
3. PARITY=1; write 0x00 -> parity bit 1; write 0x01 -> parity bit 0.
4. FIFO_DEPTH=4; burst of 6 writes on consecutive cycles while idle -> first write pops at the first tick so 5 accepted, 6th dropped with one o_Tx_Overflow pulse. If the pop has not happened, 4 accepted, and o_Tx_Ready is 0 at count=4. Frames go back-to-back with no high gap beyond stop bits; o_Tx_Active stays continuously 1.
5. Assert i_Rst_n low mid DATA of a queued burst -> o_Tx_Serial=1 and o_Fifo_Count=0 asynchronously; no o_Tx_Done pulse; after release, new write 0x55 transmits correctly.
6. UART_TX_CTS_EN defined: i_Cts_n=1, write 0x3C -> line stays high, count=1. Drop i_Cts_n -> start bit within 2+CLK_DIV+1 cycles. Raise i_Cts_n mid-frame -> frame completes and the next queued byte waits.
